// File: rtl/br_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// One-cycle registered lookup; update and flush commit at the rising clock edge.
`ifndef XLEN
`define XLEN 32
`endif

module br_predictor #(
    parameter int BTB_ENTRIES = 64,
    parameter int TAG_W       = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              lkp_valid,
    input  logic [`XLEN-1:0]  lkp_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [`XLEN-1:0]  pred_npc,
    input  logic              upd_valid,
    input  logic [`XLEN-1:0]  upd_pc,
    input  logic              upd_taken,
    input  logic [`XLEN-1:0]  upd_target,
    input  logic              upd_uncond,
    input  logic              flush_all
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + TAG_W + 1;

    // Table storage; valid and ctr are reset, tag and target are not
    logic             valid_q  [BTB_ENTRIES];
    logic             valid_d  [BTB_ENTRIES];
    logic [1:0]       ctr_q    [BTB_ENTRIES];
    logic [1:0]       ctr_d    [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_d    [BTB_ENTRIES];
    logic [`XLEN-1:0] target_q [BTB_ENTRIES];
    logic [`XLEN-1:0] target_d [BTB_ENTRIES];

    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic [`XLEN-1:0] pred_npc_q,   pred_npc_d;

    logic [IDX_W-1:0] lkp_idx, upd_idx;
    logic [TAG_W-1:0] lkp_tag, upd_tag;
    logic             lkp_hit, upd_hit;

    // PC bits outside index/tag do not participate in the lookup
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lkp_pc[1:0], lkp_pc[`XLEN-1:TAG_HI+1],
                              upd_pc[1:0], upd_pc[`XLEN-1:TAG_HI+1]};

    assign lkp_idx = lkp_pc[IDX_W+1:2];
    assign lkp_tag = lkp_pc[TAG_HI:TAG_LO];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[TAG_HI:TAG_LO];

    assign lkp_hit = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Lookup: reads current (pre-update, pre-flush) table contents
    always_comb begin
        pred_valid_d = lkp_valid;
        pred_taken_d = 1'b0;
        pred_npc_d   = '0;
        if (lkp_valid) begin
            pred_taken_d = lkp_hit && ctr_q[lkp_idx][1];
            pred_npc_d   = pred_taken_d ? target_q[lkp_idx] : (lkp_pc + `XLEN'(4));
        end
    end

    // Table next state: flush beats update; a not-taken miss leaves the table alone
    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (flush_all) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_uncond) begin
                    ctr_d[upd_idx] = 2'd3;
                end else if (upd_taken) begin
                    if (ctr_q[upd_idx] != 2'd3) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
                end else begin
                    if (ctr_q[upd_idx] != 2'd0) ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
                end
                if (upd_taken) target_d[upd_idx] = upd_target;
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = upd_uncond ? 2'd3 : 2'd2;
            end
        end
    end

    // Reset-bearing state: valid bits, counters and the prediction register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'd1;
            end
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_npc_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            ctr_q        <= ctr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_npc_q   <= pred_npc_d;
        end
    end

    // Tag and target payload; only meaningful while the valid bit is set
    always_ff @(posedge clock) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_npc   = pred_npc_q;

endmodule

// File: tb/tb_br_predictor.sv
// Directed testbench for br_predictor (BTB_ENTRIES=64, TAG_W=10).
`ifndef XLEN
`define XLEN 32
`endif

module tb_br_predictor;

    logic              clock = 1'b0;
    logic              reset;
    logic              lkp_valid;
    logic [`XLEN-1:0]  lkp_pc;
    logic              pred_valid;
    logic              pred_taken;
    logic [`XLEN-1:0]  pred_npc;
    logic              upd_valid;
    logic [`XLEN-1:0]  upd_pc;
    logic              upd_taken;
    logic [`XLEN-1:0]  upd_target;
    logic              upd_uncond;
    logic              flush_all;

    int checks   = 0;
    int failures = 0;

    br_predictor #(.BTB_ENTRIES(64), .TAG_W(10)) dut (
        .clock      (clock),
        .reset      (reset),
        .lkp_valid  (lkp_valid),
        .lkp_pc     (lkp_pc),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_npc   (pred_npc),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .upd_uncond (upd_uncond),
        .flush_all  (flush_all)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        lkp_valid  = 1'b0;
        lkp_pc     = '0;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
        upd_uncond = 1'b0;
        flush_all  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic upd(input logic [`XLEN-1:0] pc, input logic tk,
                       input logic [`XLEN-1:0] tgt, input logic unc);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        upd_uncond = unc;
        tick();
        upd_valid  = 1'b0;
        upd_taken  = 1'b0;
        upd_uncond = 1'b0;
    endtask

    task automatic lkp(input logic [`XLEN-1:0] pc);
        lkp_valid = 1'b1;
        lkp_pc    = pc;
        tick();
        lkp_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        checks++; if (pred_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", pred_valid); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_taken got=%0b exp=0", pred_taken); end
        checks++; if (pred_npc !== 32'h0) begin failures++; $display("FAIL reset_npc got=%h exp=0", pred_npc); end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_cold_miss();
        do_reset();
        lkp(32'h100);
        checks++; if (pred_valid !== 1'b1) begin failures++; $display("FAIL cold_valid got=%0b exp=1", pred_valid); end
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL cold_taken got=%0b exp=0", pred_taken); end
        checks++; if (pred_npc !== 32'h104) begin failures++; $display("FAIL cold_npc got=%h exp=104", pred_npc); end
        tick();
        checks++; if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || pred_npc !== 32'h0) begin
            failures++; $display("FAIL idle_zero got=%0b/%0b/%h exp=0/0/0", pred_valid, pred_taken, pred_npc); end
    endtask

    task automatic test_alloc_hit();
        do_reset();
        upd(32'h100, 1'b1, 32'h40, 1'b0);
        lkp(32'h100);
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL alloc_taken got=%0b exp=1", pred_taken); end
        checks++; if (pred_npc !== 32'h40) begin failures++; $display("FAIL alloc_npc got=%h exp=40", pred_npc); end
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        lkp(32'h100);
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL nt_taken got=%0b exp=0", pred_taken); end
        checks++; if (pred_npc !== 32'h104) begin failures++; $display("FAIL nt_npc got=%h exp=104", pred_npc); end
        // ctr is now 0; one taken update -> 1, still not-taken, target stays updated
        upd(32'h100, 1'b1, 32'h48, 1'b0);
        lkp(32'h100);
        checks++; if (pred_taken !== 1'b0 || pred_npc !== 32'h104) begin
            failures++; $display("FAIL ctr_floor got=%0b/%h exp=0/104", pred_taken, pred_npc); end
        upd(32'h100, 1'b1, 32'h4c, 1'b0);
        lkp(32'h100);
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h4c) begin
            failures++; $display("FAIL retarget got=%0b/%h exp=1/4c", pred_taken, pred_npc); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 5; i++) upd(32'h200, 1'b1, 32'h80, 1'b0);
        upd(32'h200, 1'b0, 32'h0, 1'b0);
        lkp(32'h200);
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h80) begin
            failures++; $display("FAIL sat_hi got=%0b/%h exp=1/80", pred_taken, pred_npc); end
        // ctr 2 -> 1; JAL must force 3 (a plain increment would give 2)
        upd(32'h200, 1'b0, 32'h0, 1'b0);
        upd(32'h200, 1'b1, 32'h90, 1'b1);
        upd(32'h200, 1'b0, 32'h0, 1'b0);
        lkp(32'h200);
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h90) begin
            failures++; $display("FAIL jal_force got=%0b/%h exp=1/90", pred_taken, pred_npc); end
        // JAL miss allocates with ctr=3: survives one not-taken
        upd(32'h284, 1'b1, 32'ha0, 1'b1);
        upd(32'h284, 1'b0, 32'h0, 1'b0);
        lkp(32'h284);
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'ha0) begin
            failures++; $display("FAIL jal_alloc got=%0b/%h exp=1/a0", pred_taken, pred_npc); end
    endtask

    task automatic test_alias();
        do_reset();
        upd(32'h100, 1'b1, 32'h40, 1'b0);
        lkp(32'h200);
        checks++; if (pred_taken !== 1'b0 || pred_npc !== 32'h204) begin
            failures++; $display("FAIL alias_miss got=%0b/%h exp=0/204", pred_taken, pred_npc); end
        upd(32'h200, 1'b0, 32'h0, 1'b0);
        lkp(32'h100);
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h40) begin
            failures++; $display("FAIL alias_intact got=%0b/%h exp=1/40", pred_taken, pred_npc); end
    endtask

    task automatic test_collision();
        do_reset();
        lkp_valid  = 1'b1;
        lkp_pc     = 32'h300;
        upd_valid  = 1'b1;
        upd_pc     = 32'h300;
        upd_taken  = 1'b1;
        upd_target = 32'h500;
        tick();
        idle_inputs();
        checks++; if (pred_taken !== 1'b0 || pred_npc !== 32'h304) begin
            failures++; $display("FAIL coll_same got=%0b/%h exp=0/304", pred_taken, pred_npc); end
        lkp(32'h300);
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h500) begin
            failures++; $display("FAIL coll_next got=%0b/%h exp=1/500", pred_taken, pred_npc); end
    endtask

    task automatic test_flush();
        do_reset();
        upd(32'h400, 1'b1, 32'h600, 1'b0);
        flush_all  = 1'b1;
        upd_valid  = 1'b1;
        upd_pc     = 32'h400;
        upd_taken  = 1'b1;
        upd_target = 32'h700;
        lkp_valid  = 1'b1;
        lkp_pc     = 32'h400;
        tick();
        idle_inputs();
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h600) begin
            failures++; $display("FAIL flush_pre got=%0b/%h exp=1/600", pred_taken, pred_npc); end
        lkp(32'h400);
        checks++; if (pred_taken !== 1'b0 || pred_npc !== 32'h404) begin
            failures++; $display("FAIL flush_miss got=%0b/%h exp=0/404", pred_taken, pred_npc); end
        flush_all = 1'b1;
        upd(32'h500, 1'b1, 32'h800, 1'b0);
        flush_all = 1'b0;
        lkp(32'h500);
        checks++; if (pred_taken !== 1'b0 || pred_npc !== 32'h504) begin
            failures++; $display("FAIL flush_noalloc got=%0b/%h exp=0/504", pred_taken, pred_npc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        upd(32'h100, 1'b1, 32'h40, 1'b0);
        lkp(32'h100);
        checks++; if (pred_valid !== 1'b1 || pred_taken !== 1'b1 || pred_npc !== 32'h40) begin
            failures++; $display("FAIL pre_async got=%0b/%0b/%h exp=1/1/40", pred_valid, pred_taken, pred_npc); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || pred_npc !== 32'h0) begin
            failures++; $display("FAIL async_clear got=%0b/%0b/%h exp=0/0/0", pred_valid, pred_taken, pred_npc); end
        lkp_valid  = 1'b1;
        lkp_pc     = 32'h100;
        upd_valid  = 1'b1;
        upd_pc     = 32'h700;
        upd_taken  = 1'b1;
        upd_target = 32'h900;
        tick();
        checks++; if (pred_valid !== 1'b0 || pred_npc !== 32'h0) begin
            failures++; $display("FAIL in_reset got=%0b/%h exp=0/0", pred_valid, pred_npc); end
        idle_inputs();
        reset = 1'b0;
        lkp(32'h100);
        checks++; if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_npc !== 32'h104) begin
            failures++; $display("FAIL post_reset got=%0b/%0b/%h exp=1/0/104", pred_valid, pred_taken, pred_npc); end
        lkp(32'h700);
        checks++; if (pred_taken !== 1'b0 || pred_npc !== 32'h704) begin
            failures++; $display("FAIL reset_upd got=%0b/%h exp=0/704", pred_taken, pred_npc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        upd(32'h1008, 1'b1, 32'h2000, 1'b0);
        lkp_valid = 1'b1;
        lkp_pc    = 32'h1008;
        tick();
        checks++; if (pred_taken !== 1'b1 || pred_npc !== 32'h2000) begin
            failures++; $display("FAIL b2b_hit got=%0b/%h exp=1/2000", pred_taken, pred_npc); end
        lkp_pc = 32'hFFFF_FFFC;
        tick();
        checks++; if (pred_valid !== 1'b1 || pred_taken !== 1'b0 || pred_npc !== 32'h0) begin
            failures++; $display("FAIL wrap got=%0b/%0b/%h exp=1/0/0", pred_valid, pred_taken, pred_npc); end
        lkp_pc = 32'h100C;
        tick();
        checks++; if (pred_taken !== 1'b0 || pred_npc !== 32'h1010) begin
            failures++; $display("FAIL b2b_miss got=%0b/%h exp=0/1010", pred_taken, pred_npc); end
        lkp_valid = 1'b0;
        lkp_pc    = 32'h1008;
        tick();
        checks++; if (pred_valid !== 1'b0 || pred_taken !== 1'b0 || pred_npc !== 32'h0) begin
            failures++; $display("FAIL b2b_idle got=%0b/%0b/%h exp=0/0/0", pred_valid, pred_taken, pred_npc); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        #1;
        test_reset();
        test_cold_miss();
        test_alloc_hit();
        test_saturation();
        test_alias();
        test_collision();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
